// File: rtl/dw_conv_scheduler.sv
// Sequences a CxHxW feature map (row, column, channel order) through the depthwise
// engine handshake and counts results. Define DW_SCHED_TIMEOUT_EN to add a drain watchdog.
module dw_conv_scheduler #(
    parameter int DATA_WIDTH     = 16,
    parameter int ADDR_W         = 18,
    parameter int CNT_W          = 24,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [7:0]            cfg_channels,
    input  logic [7:0]            cfg_height,
    input  logic [7:0]            cfg_width,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  buf_rd_en,
    output logic [ADDR_W-1:0]     buf_rd_addr,
    input  logic [DATA_WIDTH-1:0] buf_rd_data,
    output logic                  eng_valid,
    output logic [DATA_WIDTH-1:0] eng_data,
    output logic [7:0]            eng_channel,
    output logic [7:0]            eng_row,
    output logic [7:0]            eng_col,
    input  logic                  eng_ready,
    input  logic                  eng_out_valid
);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPTURE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              cfg_c_q, cfg_c_d, cfg_h_q, cfg_h_d, cfg_w_q, cfg_w_d;
    logic [7:0]              ch_q, ch_d, row_q, row_d, col_q, col_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [CNT_W-1:0]        total_q, total_d, out_cnt_q, out_cnt_d;
    logic                    busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic                    rd_en_q, rd_en_d, eng_valid_q, eng_valid_d;
    logic [DATA_WIDTH-1:0]   eng_data_q, eng_data_d;
    logic [7:0]              eng_ch_q, eng_ch_d, eng_row_q, eng_row_d, eng_col_q, eng_col_d;
    logic                    last_pix;
`ifdef DW_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]         wd_q, wd_d;
`endif

    always_comb begin
        state_d     = state_q;
        cfg_c_d     = cfg_c_q;
        cfg_h_d     = cfg_h_q;
        cfg_w_d     = cfg_w_q;
        ch_d        = ch_q;
        row_d       = row_q;
        col_d       = col_q;
        addr_d      = addr_q;
        total_d     = total_q;
        out_cnt_d   = out_cnt_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rd_en_d     = 1'b0;
        eng_valid_d = eng_valid_q;
        eng_data_d  = eng_data_q;
        eng_ch_d    = eng_ch_q;
        eng_row_d   = eng_row_q;
        eng_col_d   = eng_col_q;
`ifdef DW_SCHED_TIMEOUT_EN
        wd_d        = wd_q;
`endif
        last_pix = (ch_q == cfg_c_q - 8'd1) && (col_q == cfg_w_q - 8'd1) &&
                   (row_q == cfg_h_q - 8'd1);

        // Results are counted in every busy state, independent of the issue side.
        if (busy_q && eng_out_valid) begin
            if (out_cnt_q == total_q) begin
                err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cfg_c_d   = cfg_channels;
                    cfg_h_d   = cfg_height;
                    cfg_w_d   = cfg_width;
                    total_d   = CNT_W'(cfg_channels) * CNT_W'(cfg_height) * CNT_W'(cfg_width);
                    out_cnt_d = '0;
                    ch_d      = '0;
                    row_d     = '0;
                    col_d     = '0;
                    addr_d    = '0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
`ifdef DW_SCHED_TIMEOUT_EN
                    wd_d      = '0;
`endif
                    if (cfg_channels == 8'd0 || cfg_height == 8'd0 || cfg_width == 8'd0) begin
                        err_d   = 1'b1;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_READ: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                eng_data_d  = buf_rd_data;
                eng_ch_d    = ch_q;
                eng_row_d   = row_q;
                eng_col_d   = col_q;
                eng_valid_d = 1'b1;
                state_d     = S_ISSUE;
            end
            S_ISSUE: begin
                if (eng_ready) begin
                    eng_valid_d = 1'b0;
                    addr_d      = addr_q + ADDR_W'(1);
                    if (ch_q == cfg_c_q - 8'd1) begin
                        ch_d = '0;
                        if (col_q == cfg_w_q - 8'd1) begin
                            col_d = '0;
                            row_d = row_q + 8'd1;
                        end else begin
                            col_d = col_q + 8'd1;
                        end
                    end else begin
                        ch_d = ch_q + 8'd1;
                    end
                    if (last_pix) begin
                        state_d = S_DRAIN;
                    end else begin
                        rd_en_d = 1'b1;
                        state_d = S_READ;
                    end
                end
            end
            S_DRAIN: begin
`ifdef DW_SCHED_TIMEOUT_EN
                wd_d = eng_out_valid ? '0 : wd_q + WD_W'(1);
`endif
                if (out_cnt_q == total_q) begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
`ifdef DW_SCHED_TIMEOUT_EN
                else if (!eng_out_valid && wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
`endif
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cfg_c_q     <= '0;
            cfg_h_q     <= '0;
            cfg_w_q     <= '0;
            ch_q        <= '0;
            row_q       <= '0;
            col_q       <= '0;
            addr_q      <= '0;
            total_q     <= '0;
            out_cnt_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rd_en_q     <= 1'b0;
            eng_valid_q <= 1'b0;
            eng_data_q  <= '0;
            eng_ch_q    <= '0;
            eng_row_q   <= '0;
            eng_col_q   <= '0;
`ifdef DW_SCHED_TIMEOUT_EN
            wd_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cfg_c_q     <= cfg_c_d;
            cfg_h_q     <= cfg_h_d;
            cfg_w_q     <= cfg_w_d;
            ch_q        <= ch_d;
            row_q       <= row_d;
            col_q       <= col_d;
            addr_q      <= addr_d;
            total_q     <= total_d;
            out_cnt_q   <= out_cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rd_en_q     <= rd_en_d;
            eng_valid_q <= eng_valid_d;
            eng_data_q  <= eng_data_d;
            eng_ch_q    <= eng_ch_d;
            eng_row_q   <= eng_row_d;
            eng_col_q   <= eng_col_d;
`ifdef DW_SCHED_TIMEOUT_EN
            wd_q        <= wd_d;
`endif
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign err         = err_q;
    assign buf_rd_en   = rd_en_q;
    assign buf_rd_addr = addr_q;
    assign eng_valid   = eng_valid_q;
    assign eng_data    = eng_data_q;
    assign eng_channel = eng_ch_q;
    assign eng_row     = eng_row_q;
    assign eng_col     = eng_col_q;

endmodule
